// File: rtl/spmv_csr_sched.sv
// spmv_csr_sched: loads the CSR row-pointer table, then streams value/vector operand pairs to the SpMV core.
module spmv_csr_sched #(
  parameter int ELEM_CYCLES = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_err,
  output logic [4:0]   o_ptr_addr,
  input  logic [7:0]   i_ptr_data,
  output logic [7:0]   o_nz_addr,
  input  logic [15:0]  i_val_data,
  input  logic [3:0]   i_col_data,
  output logic [3:0]   o_x_addr,
  input  logic [15:0]  i_x_data,
  output logic         o_core_start,
  output logic [15:0]  o_data_A,
  output logic [15:0]  o_data_B,
  output logic [7:0]   o_count,
  output logic [135:0] o_row_ptr
);
  typedef enum logic [3:0] {IDLE, PTR_RD, PTR_LAST, CHECK, NZ_RD, X_RD, X_CAP, ISSUE, DONE} state_t;
  state_t state, state_n;
  logic [4:0]  pcnt;
  logic [7:0]  k;
  logic [3:0]  ecnt;
  logic [15:0] val_q, x_q;
  logic [7:0]  rp [17];
  logic        bad, last_e, last_k;
  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < 16; i++) bad = bad | (rp[i+1] < rp[i]);
  end
  assign last_e = ecnt == 4'(ELEM_CYCLES - 1);
  assign last_k = (k + 8'd1) == rp[16];
  always_ff @(posedge i_clk) state <= i_rst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = i_start ? PTR_RD : IDLE;
      PTR_RD:   state_n = pcnt == 5'd16 ? PTR_LAST : PTR_RD;
      PTR_LAST: state_n = CHECK;
      CHECK:    state_n = (bad || rp[16] == 8'd0) ? DONE : NZ_RD;
      NZ_RD:    state_n = X_RD;
      X_RD:     state_n = X_CAP;
      X_CAP:    state_n = ISSUE;
      ISSUE:    state_n = !last_e ? ISSUE : last_k ? DONE : NZ_RD;
      DONE:     state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pcnt    <= '0;
      k       <= '0;
      ecnt    <= '0;
      val_q   <= '0;
      x_q     <= '0;
      o_count <= '0;
      o_err   <= 1'b0;
      for (int i = 0; i < 17; i++) rp[i] <= '0;
    end else begin
      pcnt <= state == PTR_RD ? pcnt + 5'd1 : 5'd0;
      ecnt <= state == ISSUE ? ecnt + 4'd1 : 4'd0;
      // read data trails its address by one cycle, so capture into the previous slot
      if ((state == PTR_RD && pcnt != 5'd0) || state == PTR_LAST) rp[pcnt - 5'd1] <= i_ptr_data;
      if (state == IDLE && i_start) begin
        o_err   <= 1'b0;
        k       <= '0;
        o_count <= '0;
      end
      if (state == CHECK && bad) o_err <= 1'b1;
      if (state == X_RD) val_q <= i_val_data;
      if (state == X_CAP) begin
        x_q     <= i_x_data;
        o_count <= k + 8'd1;
      end
      if (state == ISSUE && last_e && !last_k) k <= k + 8'd1;
    end
  end
  assign o_busy       = state != IDLE;
  assign o_done       = state == DONE;
  assign o_ptr_addr   = state == PTR_RD ? pcnt : 5'd0;
  assign o_nz_addr    = state == NZ_RD ? k : 8'd0;
  assign o_x_addr     = state == X_RD ? i_col_data : 4'd0;
  assign o_data_A     = state == ISSUE ? x_q : 16'd0;
  assign o_data_B     = state == ISSUE ? val_q : 16'd0;
  assign o_core_start = state == ISSUE && ecnt == 4'd0 && k == 8'd0;
  for (genvar g = 0; g < 17; g++) assign o_row_ptr[8*g +: 8] = rp[g];
endmodule

// File: doc/spmv_csr_sched.md
# spmv_csr_sched

CSR fetch scheduler for the SpMV datapath. On a start request it loads the 17-entry row-pointer table, then walks every nonzero in order. For each nonzero it fetches the matrix value and column index, then the dense-vector element at that column, and presents the operand pair to the SpMV core together with the running nonzero count and the packed row-pointer bus. It replaces hand-driven testbench stimulus and is the only master of the three CSR/vector read ports.

## Interface
- ELEM_CYCLES, 4, cycles each operand pair is held on the core inputs (core per-element period); legal 2..15
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_start  in  1  start request, sampled in IDLE only
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle pulse at end of job (also on error)
- o_err  out  1  row-pointer table not monotonic; valid with o_done, held until next start
- o_ptr_addr  out  5  row_ptr memory address (0..16)
- i_ptr_data  in  8  row_ptr read data, 1-cycle synchronous read latency
- o_nz_addr  out  8  shared address for value and column-index memories
- i_val_data  in  16  fp16 matrix value, 1-cycle latency
- i_col_data  in  4  column index, 1-cycle latency
- o_x_addr  out  4  dense-vector memory address
- i_x_data  in  16  fp16 vector element, 1-cycle latency
- o_core_start  out  1  one-cycle start pulse to core
- o_data_A  out  16  vector element to core
- o_data_B  out  16  matrix value to core
- o_count  out  8  1-based index of nonzero currently presented
- o_row_ptr  out  136  row_ptr[i] at bits [8i +: 8], i = 0..16

## Operation
- States: IDLE, PTR_RD, PTR_LAST, CHECK, NZ_RD, X_RD, X_CAP, ISSUE, DONE.
- IDLE: i_start → PTR_RD, clear o_err, element index k = 0. i_start in any other state is ignored.
- PTR_RD, 17 cycles: o_ptr_addr = 0..16, one per cycle. Data for address a is captured into o_row_ptr entry a one cycle later.
- PTR_LAST, 1 cycle: captures entry 16. nnz = row_ptr[16].
- CHECK, 1 cycle:
  - If row_ptr[i+1] < row_ptr[i] for any i in 0..15 → set o_err, go to DONE.
  - Else if nnz == 0 → DONE.
  - Else → NZ_RD.
- NZ_RD: o_nz_addr = k.
- X_RD: latch i_val_data; o_x_addr = i_col_data.
- X_CAP: latch i_x_data.
- ISSUE, ELEM_CYCLES cycles:
  - o_data_A = latched x, o_data_B = latched value, o_count = k+1.
  - o_core_start is high in the first ISSUE cycle of k = 0 only.
  - On the last cycle: if k+1 == nnz → DONE, else k = k+1 → NZ_RD.
- DONE, 1 cycle: o_done = 1 → IDLE.
- o_data_A/o_data_B are 0 outside ISSUE.
- o_count holds its last value through DONE/IDLE until the next start. It is cleared to 0 on entry to PTR_RD.
- o_row_ptr holds until overwritten by the next PTR_RD.
- Address outputs are 0 in states that do not use them.
- row_ptr[0] ≠ 0 is legal: the walk still starts at k = 0 and ends at nnz−1.
- Entries of 255 are legal, so nnz can reach 255; no wrap occurs because k ≤ 254.

## Timing
- Reset: all outputs 0, state IDLE, o_row_ptr 0, k 0. Reset asserted mid-job aborts at the next edge. No o_done is emitted, and memory addresses return to 0.
- Start sampled at edge 0:
  - PTR_RD occupies cycles 1–17.
  - PTR_LAST occupies cycle 18.
  - CHECK occupies cycle 19.
  - Element k starts NZ_RD at cycle 20 + k·(3+ELEM_CYCLES).
  - ISSUE for element k starts 3 cycles after its NZ_RD.
- o_done occurs at cycle 20 + nnz·(3+ELEM_CYCLES). For nnz = 0 or on error this is cycle 20.
- o_busy is high from cycle 1 through the DONE cycle inclusive.
- A start asserted in the same cycle as DONE is ignored. A start one cycle later, in IDLE, is accepted.

## Test plan
- Reset, then idle with i_start = 0 for 10 cycles → all outputs 0, o_busy = 0.
- row_ptr = {0,1,1,…,1} (nnz = 1), val[0] = 16'h3C00, col[0] = 3, x[3] = 16'h4000, ELEM_CYCLES = 4:
  - cycles 23–26: o_data_A = 16'h4000, o_data_B = 16'h3C00, o_count = 1;
  - o_core_start at cycle 23 only;
  - o_done at cycle 27.
- row_ptr = {0,2,4,…,32} (nnz = 32):
  - o_count steps 1..32, each value held 4 cycles;
  - o_x_addr follows col[k] each element;
  - o_done at cycle 20 + 32·7 = 244;
  - o_row_ptr equals the table throughout.
- All row_ptr = 0 → o_done at cycle 20, o_err = 0, no ISSUE cycles, o_core_start never asserted.
- row_ptr[5] = 7, row_ptr[6] = 4 → o_done and o_err at cycle 20; o_err holds until the next start.
- Reset pulsed at cycle 30 of an nnz = 8 job, then restart with nnz = 1 → no o_done from the aborted job; second job timing as in scenario 2.
